// File: rtl/dino_jump_if.sv
// dino_jump_if - signal bundle between the game-control environment and the
// dino vertical-motion controller.
//   frame_tick : one-cycle pulse per video frame
//   game_run   : 1 = game active, 0 = everything frozen
//   jump_btn   : debounced jump button (level)
//   collide    : collision flag (level)
//   restart    : one-cycle pulse that leaves DEAD
//   pos        : sprite bottom row (screen y)
//   state      : GROUND=0, RISE=1, FALL=2, DEAD=3
//   airborne   : state is RISE or FALL
//   dead       : state is DEAD
//   landed     : one-cycle pulse on touchdown
// master = environment side (drives controls), slave = controller side.
interface dino_jump_if;
  logic       frame_tick;
  logic       game_run;
  logic       jump_btn;
  logic       collide;
  logic       restart;
  logic [8:0] pos;
  logic [1:0] state;
  logic       airborne;
  logic       dead;
  logic       landed;

  modport master (
    output frame_tick, game_run, jump_btn, collide, restart,
    input  pos, state, airborne, dead, landed
  );

  modport slave (
    input  frame_tick, game_run, jump_btn, collide, restart,
    output pos, state, airborne, dead, landed
  );
endinterface

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl - per-frame vertical-motion controller for the dino sprite.
// Turns jump presses into a ground/rise/fall/dead trajectory with integer
// gravity and drives the sprite bottom row. Motion advances once per
// frame_tick; all outputs are registered.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : dino_jump_if.slave (controls in, pos/state/flags out)
module dino_jump_ctrl #(
  parameter int GROUND_Y = 300,
  parameter int MIN_Y    = 100,
  parameter int JUMP_V0  = 12,
  parameter int SHORT_V  = 4,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 15
) (
  input  logic          clk,
  input  logic          rst,
  dino_jump_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_DEAD   = 2'd3
  } state_e;

  localparam logic [8:0] GROUND_Y_W = 9'(GROUND_Y);
  localparam logic [9:0] GROUND_Y_X = 10'(GROUND_Y);
  localparam logic [8:0] MIN_Y_W    = 9'(MIN_Y);
  localparam logic [5:0] JUMP_V0_W  = 6'(JUMP_V0);
  localparam logic [5:0] SHORT_V_W  = 6'(SHORT_V);
  localparam logic [5:0] GRAVITY_W  = 6'(GRAVITY);
  localparam logic [5:0] MAX_FALL_W = 6'(MAX_FALL);

  state_e     state_q, state_d;
  logic [8:0] pos_q, pos_d;
  logic [5:0] vel_q, vel_d;
  logic       jump_req_q, jump_req_d;
  logic       btn_q, btn_d;
  logic       landed_q, landed_d;
  logic       airborne_q, airborne_d;
  logic       dead_q, dead_d;

  logic              btn_edge_s;
  logic [5:0]        v_eff_s;
  logic signed [9:0] rise_pos_s;
  logic [6:0]        fall_sum_s;
  logic [5:0]        vn_s;
  logic [9:0]        fall_pos_s;

  // Releasing the button caps the rise speed, giving variable jump height.
  assign btn_edge_s = bus.jump_btn & ~btn_q;
  assign v_eff_s    = (!bus.jump_btn && (vel_q > SHORT_V_W)) ? SHORT_V_W : vel_q;
  // 10-bit arithmetic so the ceiling/floor clamps see the true result.
  assign rise_pos_s = $signed({1'b0, pos_q}) - $signed({4'b0000, v_eff_s});
  assign fall_sum_s = {1'b0, vel_q} + {1'b0, GRAVITY_W};
  assign vn_s       = (fall_sum_s > {1'b0, MAX_FALL_W}) ? MAX_FALL_W : fall_sum_s[5:0];
  assign fall_pos_s = {1'b0, pos_q} + {4'b0000, vn_s};

  // State register: all controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GROUND;
      pos_q      <= GROUND_Y_W;
      vel_q      <= 6'd0;
      jump_req_q <= 1'b0;
      btn_q      <= 1'b0;
      landed_q   <= 1'b0;
      airborne_q <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      vel_q      <= vel_d;
      jump_req_q <= jump_req_d;
      btn_q      <= btn_d;
      landed_q   <= landed_d;
      airborne_q <= airborne_d;
      dead_q     <= dead_d;
    end
  end

  // Next-state logic: freeze, death/restart, launch and per-frame motion.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    vel_d      = vel_q;
    jump_req_d = jump_req_q;
    btn_d      = btn_q;
    landed_d   = 1'b0;
    if (!bus.game_run) begin
      // Frozen: nothing moves and no button edge is latched.
      btn_d = btn_q;
    end else if (state_q == ST_DEAD) begin
      btn_d = bus.jump_btn;
      // restart beats a same-cycle collide.
      if (bus.restart) begin
        state_d    = ST_GROUND;
        pos_d      = GROUND_Y_W;
        vel_d      = 6'd0;
        jump_req_d = 1'b0;
      end else begin
        state_d = ST_DEAD;
      end
    end else if (bus.collide) begin
      // Collision beats a same-cycle tick: no motion update.
      btn_d      = bus.jump_btn;
      state_d    = ST_DEAD;
      jump_req_d = 1'b0;
    end else begin
      btn_d = bus.jump_btn;
      case (state_q)
        ST_GROUND: begin
          if (bus.frame_tick && jump_req_q) begin
            // Launch tick: position unchanged, speed loaded.
            state_d    = ST_RISE;
            vel_d      = JUMP_V0_W;
            jump_req_d = 1'b0;
          end else if (btn_edge_s) begin
            jump_req_d = 1'b1;
          end else begin
            jump_req_d = jump_req_q;
          end
        end
        ST_RISE: begin
          if (bus.frame_tick) begin
            if (rise_pos_s < $signed({1'b0, MIN_Y_W})) begin
              pos_d   = MIN_Y_W;
              vel_d   = 6'd0;
              state_d = ST_FALL;
            end else begin
              pos_d = rise_pos_s[8:0];
              if (v_eff_s <= GRAVITY_W) begin
                vel_d   = 6'd0;
                state_d = ST_FALL;
              end else begin
                vel_d = v_eff_s - GRAVITY_W;
              end
            end
          end else begin
            state_d = ST_RISE;
          end
        end
        ST_FALL: begin
          if (bus.frame_tick) begin
            if (fall_pos_s >= GROUND_Y_X) begin
              pos_d    = GROUND_Y_W;
              vel_d    = 6'd0;
              state_d  = ST_GROUND;
              landed_d = 1'b1;
            end else begin
              pos_d = fall_pos_s[8:0];
              vel_d = vn_s;
            end
          end else begin
            state_d = ST_FALL;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Output decode from the next state so the flags register alongside it.
  always_comb begin
    airborne_d = (state_d == ST_RISE) || (state_d == ST_FALL);
    dead_d     = (state_d == ST_DEAD);
  end

  assign bus.pos      = pos_q;
  assign bus.state    = state_q;
  assign bus.airborne = airborne_q;
  assign bus.dead     = dead_q;
  assign bus.landed   = landed_q;

endmodule
